// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bus between the fetch and data ports,
// with a watchdog that aborts a grant whose mem_wait never drops.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  output logic [31:0] mem_address,
  output logic        mem_enable,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic [2:0]  mem_write_mode,
  output logic        mem_read_enable,
  output logic [2:0]  mem_read_mode,
  input  logic [31:0] mem_read_data,
  input  logic        mem_wait,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // 0 = fetch served last, 1 = data served last
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;
  logic             timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign timeout   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign bus_error = bus_error_q;

  // Arbitration, downstream mux and watchdog abort.
  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    bus_error_d      = bus_error_q;
    imem_wait        = imem_enable;
    dmem_wait        = dmem_enable;
    imem_data        = 32'h0;
    dmem_read_data   = 32'h0;
    mem_address      = 32'h0;
    mem_enable       = 1'b0;
    mem_write_data   = 32'h0;
    mem_write_enable = 1'b0;
    mem_write_mode   = 3'h0;
    mem_read_enable  = 1'b0;
    mem_read_mode    = 3'h0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (imem_enable && dmem_enable) begin
          state_d = last_q ? GRANT_I : GRANT_D;
        end else if (imem_enable) begin
          state_d = GRANT_I;
        end else if (dmem_enable) begin
          state_d = GRANT_D;
        end
      end

      GRANT_I: begin
        if (timeout) begin
          imem_wait   = 1'b0;
          bus_error_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          mem_address     = imem_address;
          mem_enable      = imem_enable;
          mem_read_enable = imem_enable;
          imem_wait       = mem_wait;
          imem_data       = mem_read_data;
          if (!mem_wait) begin
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = dmem_enable ? GRANT_D : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      GRANT_D: begin
        if (timeout) begin
          dmem_wait   = 1'b0;
          bus_error_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          mem_address      = dmem_address;
          mem_enable       = dmem_enable;
          mem_write_data   = dmem_write_data;
          mem_write_enable = dmem_write_enable;
          mem_write_mode   = dmem_write_mode;
          mem_read_enable  = dmem_read_enable;
          mem_read_mode    = dmem_read_mode;
          dmem_wait        = mem_wait;
          dmem_read_data   = mem_read_data;
          if (!mem_wait) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = imem_enable ? GRANT_I : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
